// File: rtl/cr_kme_fifo_arb_pkg.sv
// cr_kme_fifo_arb_pkg: shared widths, FSM states and FIFO entry layout for the KME RAM FIFO arbiter
package cr_kme_fifo_arb_pkg;
    localparam int FIFO_W     = 71;
    localparam int TAG_W_DEF  = 2;
    localparam int DATA_W_DEF = 69;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] payload;
    } entry_t;
endpackage

// File: rtl/cr_kme_rr_arb.sv
// cr_kme_rr_arb: round-robin picker, first eligible requester at or after rr_ptr wins
module cr_kme_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && eligible[(int'(rr_ptr) + k) % N]) begin
                any = 1'b1;
                idx = IW'((int'(rr_ptr) + k) % N);
                grant[(int'(rr_ptr) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cr_kme_ram_fifo_arb.sv
// cr_kme_ram_fifo_arb: credit-limited round-robin write arbiter for the shared KME RAM FIFO,
// with tag-based credit return, sticky ECC error capture and a drain sequencer.
module cr_kme_ram_fifo_arb
    import cr_kme_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CREDITS = 8,
    parameter int CNT_W   = 4,
    parameter int OCC_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [TAG_W+DATA_W-1:0]   fifo_in,
    output logic                      fifo_in_valid,
    input  logic                      fifo_in_stall,
    input  logic [TAG_W+DATA_W-1:0]   fifo_out,
    input  logic                      fifo_out_valid,
    input  logic                      fifo_out_ack,
    input  logic                      fifo_mbe,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic [OCC_W-1:0]          occupancy,
    output logic                      mbe_err,
    output logic [TAG_W-1:0]          mbe_tag,
    input  logic                      err_clr
);
    localparam int W = TAG_W + DATA_W;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   credit [NUM_REQ];
    logic [TAG_W-1:0]   rr_ptr, gnt_idx, rtag;
    logic [NUM_REQ-1:0] eligible, grant, ret_vec;
    logic               slot_free, retire, ret_ok, gnt_any, any;

    assign slot_free = !fifo_in_valid || !fifo_in_stall;
    assign retire    = fifo_out_valid && fifo_out_ack;
    assign rtag      = fifo_out[W-1 -: TAG_W];
    assign ret_ok    = |ret_vec;
    assign gnt_any   = slot_free && any;
    assign req_ack   = slot_free ? grant : '0;

    // A retire against a full counter is dropped so the counter saturates
    always_comb begin
        eligible = '0;
        ret_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && credit[i] != '0 && state == RUN;
            ret_vec[i]  = retire && rtag == TAG_W'(i) && credit[i] != CNT_W'(CREDITS);
        end
    end

    cr_kme_rr_arb #(.N(NUM_REQ), .IW(TAG_W)) u_arb (
        .eligible(eligible),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .idx     (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_nxt = state == RUN   ? (drain_req ? DRAIN : RUN)
                  : state == DRAIN ? (!drain_req ? RUN : (!fifo_in_valid && occupancy == '0) ? DONE : DRAIN)
                  : (drain_req ? DONE : RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            drain_done    <= 1'b0;
            fifo_in_valid <= 1'b0;
            fifo_in       <= '0;
            rr_ptr        <= '0;
            occupancy     <= '0;
            mbe_err       <= 1'b0;
            mbe_tag       <= '0;
            for (int i = 0; i < NUM_REQ; i++) credit[i] <= CNT_W'(CREDITS);
        end else begin
            state      <= state_nxt;
            drain_done <= state_nxt == DONE;
            if (slot_free) fifo_in_valid <= gnt_any;
            if (gnt_any) begin
                fifo_in <= {gnt_idx, req_data[gnt_idx*DATA_W +: DATA_W]};
                rr_ptr  <= gnt_idx == TAG_W'(NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
            end
            occupancy <= occupancy + OCC_W'(gnt_any) - OCC_W'(ret_ok);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ret_vec[i] && !req_ack[i]) credit[i] <= credit[i] + 1'b1;
                else if (req_ack[i] && !ret_vec[i]) credit[i] <= credit[i] - 1'b1;
            end
            // A fresh error wins over a same-cycle clear
            if (retire && fifo_mbe && (!mbe_err || err_clr)) begin
                mbe_err <= 1'b1;
                mbe_tag <= rtag;
            end else if (err_clr) begin
                mbe_err <= 1'b0;
                mbe_tag <= '0;
            end
        end
    end

    ap_retire_legal: assert property (@(posedge clk) disable iff (rst) retire |-> ret_ok);
endmodule
